md_unit_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU.
- Owns the HI/LO registers and executes mult/multu/div/divu over a fixed latency.
- Serves mfhi/mflo/mthi/mtlo.
- Generates the D-stage stall request while the unit is occupied, consumed by the hazard logic.

---
 rtl/md_unit_ctrl_pkg.sv | 33 +++
 rtl/md_unit_ctrl_arith.sv | 39 +++
 rtl/md_unit_ctrl.sv | 117 +++++++++++
 tb/tb_md_unit_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: MD op codes, default latencies,
// FSM state codes and the {hi,lo} result type.
package md_unit_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic md_is_launch(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// md_arith: combinational mult/multu/div/divu datapath producing {hi,lo}.
// Divide-by-zero returns the current hi/lo so the commit leaves them unchanged.
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_res_t     cur,
  output md_res_t     res
);

  logic               sgn;
  logic [63:0]        ma, mb, prod;
  logic signed [32:0] da, db, q, r;
  logic               unused_ok;

  // 33-bit signed divide covers both signednesses and makes
  // 0x80000000 / -1 land on lo=0x80000000, hi=0 without overflow.
  always_comb begin
    sgn  = (md_op == MD_MULT) || (md_op == MD_DIV);
    ma   = {{32{sgn & a[31]}}, a};
    mb   = {{32{sgn & b[31]}}, b};
    prod = ma * mb;
    da   = {sgn & a[31], a};
    db   = {sgn & b[31], b};
    q    = da / db;
    r    = da % db;
    res  = cur;
    case (md_op)
      MD_MULT, MD_MULTU: res = prod;
      MD_DIV, MD_DIVU:   if (b != 32'd0) res = {r[31:0], q[31:0]};
      default: ;
    endcase
  end

  assign unused_ok = ^{q[32], r[32]};

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle MD sequencer: owns HI/LO, runs ops for a fixed latency, raises D-stall.
// Optional MD_CANCEL_EN adds a cancel input that aborts an in-flight op.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MD_MULT_CYC,
  parameter int DIV_CYC  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC - 1);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  md_res_t     pend_q, pend_d, cur, res;
  logic        kill, launch;

`ifdef MD_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  assign start  = en && md_is_launch(md_op) && (state_q == MD_IDLE);
  assign launch = start && !kill;
  assign cur    = {hi_q, lo_q};

  md_arith u_arith (
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .cur   (cur),
    .res   (res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      MD_IDLE: begin
        if (launch) begin
          pend_d  = res;
          cnt_d   = md_is_mul(md_op) ? MULT_LD : DIV_LD;
          state_d = MD_RUN;
          busy_d  = 1'b1;
        end else if (en && md_op == MD_MTHI) begin
          hi_d = a;
        end else if (en && md_op == MD_MTLO) begin
          lo_d = a;
        end
      end
      MD_RUN: begin
        // ops arriving in E while running are dropped; stall keeps them out
        if (kill) begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == 4'd0) begin
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          state_d = MD_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = d_is_md && (start || busy_q);
  assign rd_data = (md_op == MD_MFHI) ? hi_q :
                   (md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: expected {hi,lo} queued at issue, checked when busy falls.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk, reset, en, d_is_md;
  logic [3:0]  md_op;
  logic [31:0] a, b;
  logic        start, busy, stall;
  logic [31:0] hi, lo, rd_data;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  md_unit_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .md_op   (md_op),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
`ifdef MD_CANCEL_EN
    .cancel  (cancel),
`endif
    .start   (start),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An E-stage MD op while busy means the stall failed to hold it back.
  always @(negedge clk) begin
    if (reset === 1'b1 && busy === 1'b1 && en === 1'b1 && md_op >= 4'd1 && md_op <= 4'd8) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_while_busy md_op=%0d", md_op);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Operation table: op, a, b, busy cycles, expected hi, lo
  logic [3:0]  t_op [8] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
  logic [31:0] t_a  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7,
                            32'h80000000, 32'hFFFFFFF9, 32'd7, 32'd0};
  logic [31:0] t_b  [8] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd0};
  int          t_cy [8] = '{5, 5, 10, 10, 10, 10, 10, 10};
  logic [31:0] t_hi [8] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h00000000, 32'h00000001, 32'h00000001, 32'h00000001};
  logic [31:0] t_lo [8] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'hFFFFFFFD,
                            32'h80000000, 32'h7FFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFD};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    en = 1'b1; md_op = op; a = av; b = bv;
    tick();
    en = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; md_op = MD_NONE; a = '0; b = '0; d_is_md = 1'b0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    n_cmp++; if (stall !== 1'b0 || start !== 1'b0) begin
      n_bad++; $display("FAIL reset_start_stall got=%b%b exp=00", start, stall);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_arith_table();
    exp_t e;
    int n;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{t_hi[i], t_lo[i]});
      issue(t_op[i], t_a[i], t_b[i]);
      wait_idle(n);
      n_cmp++; if (n != t_cy[i]) begin n_bad++; $display("FAIL busy_len[%0d] got=%0d exp=%0d", i, n, t_cy[i]); end
      e = sb.pop_front();
      n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL hi[%0d] got=%h exp=%h", i, hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL lo[%0d] got=%h exp=%h", i, lo, e.lo); end
    end
  endtask

  task automatic test_random_mult();
    exp_t e;
    int n;
    logic [31:0] av, bv;
    logic [63:0] p;
    for (int i = 0; i < 6; i++) begin
      av = $urandom; bv = $urandom;
      if (i[0]) p = 64'(longint'($signed(av)) * longint'($signed(bv)));
      else      p = {32'd0, av} * {32'd0, bv};
      sb.push_back('{p[63:32], p[31:0]});
      issue(i[0] ? MD_MULT : MD_MULTU, av, bv);
      wait_idle(n);
      e = sb.pop_front();
      n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL rand_mult[%0d] got=%h%h exp=%h%h", i, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      d_is_md = (pass == 0);
      sb.push_back('{32'd0, 32'd12});
      en = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd4;
      #1;
      n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL stall_start got=%b exp=1", start); end
      n_cmp++; if (stall !== d_is_md) begin n_bad++; $display("FAIL stall_launch got=%b exp=%b", stall, d_is_md); end
      tick();
      en = 1'b0; md_op = MD_NONE;
      #1;
      for (int c = 0; c < 5; c++) begin
        n_cmp++; if (busy !== 1'b1 || stall !== d_is_md) begin
          n_bad++; $display("FAIL stall_busy[%0d] busy=%b stall=%b exp=1%b", c, busy, stall, d_is_md);
        end
        tick();
      end
      n_cmp++; if (busy !== 1'b0 || stall !== 1'b0) begin
        n_bad++; $display("FAIL stall_after busy=%b stall=%b exp=00", busy, stall);
      end
      e = sb.pop_front();
      n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL stall_result got=%h%h exp=%h%h", hi, lo, e.hi, e.lo);
      end
    end
    d_is_md = 1'b0;
  endtask

  task automatic test_mtmf();
    issue(MD_MTHI, 32'h12345678, 32'd0);
    md_op = MD_MFHI; #1;
    n_cmp++; if (rd_data !== 32'h12345678) begin n_bad++; $display("FAIL mfhi got=%h exp=12345678", rd_data); end
    issue(MD_MTLO, 32'hCAFEBABE, 32'd0);
    md_op = MD_MFLO; #1;
    n_cmp++; if (rd_data !== 32'hCAFEBABE) begin n_bad++; $display("FAIL mflo got=%h exp=cafebabe", rd_data); end
    md_op = MD_MFHI; #1;
    n_cmp++; if (rd_data !== 32'h12345678) begin n_bad++; $display("FAIL mfhi_keep got=%h exp=12345678", rd_data); end
    md_op = MD_NONE; #1;
    n_cmp++; if (rd_data !== 32'd0) begin n_bad++; $display("FAIL rd_none got=%h exp=0", rd_data); end
    en = 1'b1; md_op = 4'd9; #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL op9_start got=%b exp=0", start); end
    tick();
    en = 1'b0; md_op = MD_NONE;
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin
      n_bad++; $display("FAIL op9_state busy=%b hi=%h lo=%h", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL rmid_now busy=%b hi=%h lo=%h exp=0", busy, hi, lo);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (15) tick();
    n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL rmid_after busy=%b hi=%h lo=%h exp=0", busy, hi, lo);
    end
  endtask

`ifdef MD_CANCEL_EN
  task automatic test_cancel();
    int n;
    issue(MD_MTHI, 32'hA5A5A5A5, 32'd0);
    issue(MD_MTLO, 32'h5A5A5A5A, 32'd0);
    issue(MD_MULT, 32'd7, 32'd9);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    repeat (6) tick();
    n_cmp++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin
      n_bad++; $display("FAIL cancel_hilo hi=%h lo=%h exp=a5a5a5a5 5a5a5a5a", hi, lo);
    end
    cancel = 1'b1;
    issue(MD_DIV, 32'd50, 32'd5);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel_start got=%b exp=0", busy); end
    issue(MD_MTHI, 32'h0BADF00D, 32'd0);
    cancel = 1'b0;
    n_cmp++; if (hi !== 32'h0BADF00D) begin n_bad++; $display("FAIL cancel_mthi got=%h exp=0badf00d", hi); end
    wait_idle(n);
  endtask
`endif

  initial begin
    test_reset();
    test_arith_table();
    test_random_mult();
    test_stall();
    test_mtmf();
    test_reset_mid();
`ifdef MD_CANCEL_EN
    test_cancel();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
